// File: rtl/buffer_reduce_pkg.sv
// buffer_reduce_pkg: shared constants for the FIFO reduction block.
// Op encodings, FSM state codes, sizing and the per-op identity value.
package buffer_reduce_pkg;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int LEN_W = 5;

    localparam logic [1:0] OP_SUM  = 2'b00;
    localparam logic [1:0] OP_XOR  = 2'b01;
    localparam logic [1:0] OP_UMAX = 2'b10;
    localparam logic [1:0] OP_UMIN = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Starting accumulator value; umin starts from all ones so the
    // first word always wins, every other op starts from zero.
    function automatic logic [XLEN-1:0] op_identity(
        input logic [1:0] op
    );
        return (op == OP_UMIN) ? {XLEN{1'b1}} : '0;
    endfunction

endpackage

// File: rtl/buffer_reduce_alu.sv
// reduce_alu: combinational fold step res = f(op, acc, data).
// Ports: op (2b), acc/data (XLEN), res (XLEN); sum wraps, max/min unsigned.
module reduce_alu
    import buffer_reduce_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] res
);

    always_comb begin
        res = acc;
        case (op)
            OP_SUM:  res = acc + data;
            OP_XOR:  res = acc ^ data;
            OP_UMAX: res = (data > acc) ? data : acc;
            OP_UMIN: res = (data < acc) ? data : acc;
            default: res = acc;
        endcase
    end

endmodule

// File: rtl/buffer_reduce.sv
// buffer_reduce: drains cmd_len words from the staging FIFO and folds them.
// Ports: clk/rst, cmd_* request, buffer_read_en/buffer_data, rsp_* reply, busy.
module buffer_reduce
    import buffer_reduce_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [1:0]       cmd_op,
    output logic             buffer_read_en,
    input  logic [XLEN-1:0]  buffer_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_result,
    output logic [LEN_W-1:0] rsp_len,
    output logic             busy
);

    logic [1:0]       state;
    logic [1:0]       op_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  acc_nxt;
    logic [LEN_W-1:0] len_clamp;
    logic [XLEN-1:0]  ident;

    // Handshake outputs decode straight from the state flops so no
    // input ever reaches them combinationally.
    assign cmd_ready      = (state == ST_IDLE);
    assign buffer_read_en = (state == ST_READ);
    assign busy           = (state != ST_IDLE);

    // Lengths beyond the FIFO depth saturate; we never pop more than
    // DEPTH words for one command.
    assign len_clamp = (cmd_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH)
                                                 : cmd_len;
    assign ident     = XLEN'(op_identity(cmd_op));

    reduce_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op   (op_q),
        .acc  (acc),
        .data (buffer_data),
        .res  (acc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_SUM;
            len_q      <= '0;
            cnt        <= '0;
            acc        <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_len    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        len_q <= len_clamp;
                        cnt   <= '0;
                        acc   <= ident;
                        if (len_clamp == '0) begin
                            // Nothing to read: reply with identity.
                            state      <= ST_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_result <= ident;
                            rsp_len    <= '0;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    acc <= acc_nxt;
                    cnt <= cnt + LEN_W'(1);
                    if (cnt == len_q - LEN_W'(1)) begin
                        // Last word: capture the folded value directly
                        // so the reply appears with no extra bubble.
                        state      <= ST_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= acc_nxt;
                        rsp_len    <= len_q;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_reduce.sv
// tb_buffer_reduce: scoreboard bench with a FIFO model and fold reference.
// Stimulus and response checking run in separate processes.
module tb_buffer_reduce;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_len = '0;
    logic [1:0]  cmd_op = '0;
    logic        buffer_read_en;
    logic [31:0] buffer_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_len;
    logic        busy;

    buffer_reduce dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_len        (cmd_len),
        .cmd_op         (cmd_op),
        .buffer_read_en (buffer_read_en),
        .buffer_data    (buffer_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_len        (rsp_len),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          len;
        int          t_acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mq[$];
    logic [31:0] fmem [4096];
    logic [11:0] rd;
    logic [11:0] wr = '0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          pops = 0;
    logic        prev_v = 1'b0;
    logic        rdy_rand = 1'b0;
    logic        rdy_force = 1'b1;
    logic        rdy_bit = 1'b0;

    // FIFO model: combinational head, pop on each read-enable edge.
    assign buffer_data = fmem[rd];
    always @(posedge clk or posedge rst)
        if (rst) rd <= '0;
        else if (buffer_read_en) rd <= rd + 12'd1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        rdy_bit = 1'($urandom_range(0, 1));
    end
    always_comb rsp_ready = rdy_rand ? rdy_bit : rdy_force;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [31:0] v);
        fmem[wr] = v;
        wr = wr + 12'd1;
        mq.push_back(v);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [4:0] len);
        int          n;
        logic [31:0] e;
        logic [31:0] w;
        bit          ok;
        n = (len > 16) ? 16 : int'(len);
        e = (op == 2'b11) ? 32'hFFFF_FFFF : 32'h0;
        for (int i = 0; i < n; i++) begin
            w = mq.pop_front();
            case (op)
                2'b00: e = e + w;
                2'b01: e = e ^ w;
                2'b10: if (w > e) e = w;
                default: if (w < e) e = w;
            endcase
        end
        cmd_op    = op;
        cmd_len   = len;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (cmd_ready) begin
                @(posedge clk);
                #2;
                sb.push_back('{e, n, cyc});
                pops = 0;
                ok = 1'b1;
                break;
            end
            step();
        end
        cmd_valid = 1'b0;
        if (!ok) chk("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 300; k++) begin
            if (sb.size() == 0 && cmd_ready) break;
            step();
        end
        if (k == 300) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_read_en"}, 32'(buffer_read_en), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_result"}, rsp_result, 32'd0);
        chk({tag, "_rsp_len"}, 32'(rsp_len), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: checks latency on rsp_valid rise, value on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (buffer_read_en) pops++;
            if (rsp_valid && !prev_v) begin
                if (sb.size() == 0)
                    chk("rsp_unexpected", 32'd1, 32'd0);
                else
                    chk("rsp_latency", 32'(cyc - sb[0].t_acc),
                        32'(sb[0].len));
            end
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_len", 32'(rsp_len), 32'(e.len));
                chk("pop_count", 32'(pops), 32'(e.len));
            end
            prev_v = rsp_valid;
        end
    end

    initial begin
        int k;
        logic [4:0] l;
        rst = 1'b1;
        #1;
        chk_reset_outs("reset");
        step();
        step();
        rst = 1'b0;

        for (int i = 1; i <= 4; i++) push_word(32'(i));
        issue(2'b00, 5'd4);
        drain();

        push_word(32'hFFFF_FFFF);
        push_word(32'h0000_0002);
        issue(2'b00, 5'd2);
        drain();

        issue(2'b11, 5'd0);
        drain();

        for (int i = 0; i < 16; i++)
            push_word(i == 7 ? 32'h8000_0000 : 32'(i));
        issue(2'b10, 5'd20);
        drain();

        // Response stall with a competing command held high.
        rdy_force = 1'b0;
        push_word(32'h0000_0007);
        issue(2'b00, 5'd1);
        for (k = 0; k < 50 && !rsp_valid; k++) step();
        if (k == 50) chk("stall_rsp_timeout", 32'd0, 32'd1);
        push_word(32'h5);
        push_word(32'h3);
        cmd_op    = 2'b01;
        cmd_len   = 5'd2;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("stall_result", rsp_result, 32'h7);
        end
        rdy_force = 1'b1;
        issue(2'b01, 5'd2);
        chk("stall_accept_order", 32'(sb.size()), 32'd1);
        drain();

        // Asynchronous reset while the third word is being read.
        for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
        issue(2'b01, 5'd8);
        step();
        step();
        chk("pre_rst_read_en", 32'(buffer_read_en), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_outs("midrst");
        sb.delete();
        mq.delete();
        wr = '0;
        step();
        step();
        rst = 1'b0;
        push_word(32'hA5A5_1234);
        issue(2'b01, 5'd1);
        drain();

        rdy_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            l = 5'($urandom_range(0, 31));
            for (int i = 0; i < ((l > 16) ? 16 : int'(l)); i++)
                push_word(rnd_word());
            issue(2'($urandom_range(0, 3)), l);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
